uart_tx_arbiter: RTL

Round-robin scheduler that shares one `uart_tx` serializer among `N_REQ` message sources. Each source presents a short multi-byte message, for example a 3-digit ASCII decimal string. The arbiter grants one source at a time and feeds its bytes to `uart_tx` through the `tx_start`/`tx_done` handshake. It pulses an acknowledge to the source when the last byte has left the serializer. It sits between the application blocks (ASCII processor, status reporters) and the `uart_tx` instance; `baud_gen` is unaffected.

---
 rtl/uart_tx_arbiter.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler that lets N_REQ message sources share one uart_tx serializer.
// Optional macro UART_ARB_CRLF_EN appends 0x0D 0x0A to every message before the ack.
module uart_tx_arbiter #(
    parameter int N_REQ     = 2,
    parameter int MAX_BYTES = 4,
    parameter int LEN_W     = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_REQ-1:0]             req,
    input  logic [N_REQ*LEN_W-1:0]       req_len,
    input  logic [N_REQ*8*MAX_BYTES-1:0] req_data,
    output logic [N_REQ-1:0]             req_ack,
    output logic [N_REQ-1:0]             grant,
    output logic                         busy,
    output logic                         tx_start,
    output logic [7:0]                   tx_char,
    input  logic                         tx_done
);

    localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int DATA_W = 8 * MAX_BYTES;

`ifdef UART_ARB_CRLF_EN
    typedef enum logic [1:0] {IDLE, SEND, CR, LF} state_t;
`else
    typedef enum logic [0:0] {IDLE, SEND} state_t;
`endif

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [IDX_W-1:0]    winner_q, winner_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [N_REQ-1:0]    grant_q, grant_d;
    logic [N_REQ-1:0]    ack_q, ack_d;
    logic                tx_start_q, tx_start_d;
    logic [7:0]          tx_char_q, tx_char_d;

    logic                pick_found;
    logic [IDX_W-1:0]    pick_idx;
    logic [DATA_W-1:0]   pick_data;
    logic [LEN_W-1:0]    pick_len_raw;
    logic [LEN_W-1:0]    pick_len;
    logic [7:0]          cur_byte;

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
        return {{(N_REQ-1){1'b0}}, 1'b1} << i;
    endfunction

    // Search starts one past the previous winner so every source gets a turn.
    always_comb begin
        int cand;
        cand         = 0;
        pick_found   = 1'b0;
        pick_idx     = '0;
        pick_data    = '0;
        pick_len_raw = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            cand = (int'(last_q) + off) % N_REQ;
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(cand);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                pick_data    = req_data[i*DATA_W +: DATA_W];
                pick_len_raw = req_len[i*LEN_W +: LEN_W];
            end
        end
        pick_len = (int'(pick_len_raw) > MAX_BYTES) ? LEN_W'(MAX_BYTES) : pick_len_raw;
    end

    always_comb begin
        cur_byte = 8'h00;
        for (int k = 0; k < MAX_BYTES; k++) begin
            if (idx_q == LEN_W'(k)) begin
                cur_byte = data_q[k*8 +: 8];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        winner_d   = winner_q;
        len_d      = len_q;
        idx_d      = idx_q;
        data_d     = data_q;
        grant_d    = grant_q;
        ack_d      = '0;
        tx_start_d = 1'b0;
        tx_char_d  = tx_char_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    winner_d = pick_idx;
                    len_d    = pick_len;
                    data_d   = pick_data;
                    if (pick_len != '0) begin
                        grant_d    = onehot(pick_idx);
                        tx_char_d  = pick_data[7:0];
                        tx_start_d = 1'b1;
                        idx_d      = LEN_W'(1);
                        state_d    = SEND;
                    end else begin
`ifdef UART_ARB_CRLF_EN
                        grant_d    = onehot(pick_idx);
                        tx_char_d  = 8'h0D;
                        tx_start_d = 1'b1;
                        state_d    = CR;
`else
                        ack_d  = onehot(pick_idx);
                        last_d = pick_idx;
`endif
                    end
                end
            end
            SEND: begin
                if (tx_done) begin
                    if (idx_q < len_q) begin
                        tx_char_d  = cur_byte;
                        tx_start_d = 1'b1;
                        idx_d      = idx_q + LEN_W'(1);
                    end else begin
`ifdef UART_ARB_CRLF_EN
                        tx_char_d  = 8'h0D;
                        tx_start_d = 1'b1;
                        state_d    = CR;
`else
                        ack_d   = onehot(winner_q);
                        grant_d = '0;
                        last_d  = winner_q;
                        state_d = IDLE;
`endif
                    end
                end
            end
`ifdef UART_ARB_CRLF_EN
            CR: begin
                if (tx_done) begin
                    tx_char_d  = 8'h0A;
                    tx_start_d = 1'b1;
                    state_d    = LF;
                end
            end
            LF: begin
                if (tx_done) begin
                    ack_d   = onehot(winner_q);
                    grant_d = '0;
                    last_d  = winner_q;
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_q     <= IDX_W'(N_REQ - 1);
            winner_q   <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            data_q     <= '0;
            grant_q    <= '0;
            ack_q      <= '0;
            tx_start_q <= 1'b0;
            tx_char_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            winner_q   <= winner_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            grant_q    <= grant_d;
            ack_q      <= ack_d;
            tx_start_q <= tx_start_d;
            tx_char_q  <= tx_char_d;
        end
    end

    assign req_ack  = ack_q;
    assign grant    = grant_q;
    assign busy     = (state_q != IDLE);
    assign tx_start = tx_start_q;
    assign tx_char  = tx_char_q;

endmodule
